// File: rtl/instr_encoder_if.sv
// Symbolic-instruction input channel and encoded-word output channel of instr_encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32IM instruction encoder: packs symbolic instructions into 32-bit words
// with sequential word addresses behind a single-entry output register.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;
  localparam logic [6:0]  F7_MUL    = 7'b0000001;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              in_ready_c, in_hs, out_hs, start_acc, wrap_c;
  logic [5:0]        op, sub;
  logic [31:0]       imm, enc_c;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              i_ok, b_ok, j_ok, bad_imm, bad_op;

  assign op  = bus.in_op;
  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  // Signed range checks reduce to "upper bits are a pure sign extension".
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  assign in_ready_c   = (state == RUN) & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = in_ready_c;
  assign in_hs        = bus.in_valid & in_ready_c;
  assign out_hs       = bus.out_valid & bus.out_ready;
  assign start_acc    = (state == IDLE) & start;
  assign wrap_c       = ~bus.in_last & (cnt == {ADDR_W{1'b1}});

  // Op index -> format, funct3/funct7 and immediate scrambling.
  always_comb begin
    sub     = '0;
    f3      = '0;
    f7      = '0;
    enc_c   = '0;
    bad_imm = 1'b0;
    bad_op  = 1'b0;
    if (op <= 6'd1) begin
      enc_c   = {imm[31:12], rd, (op == 6'd0) ? OP_LUI : OP_AUIPC};
      bad_imm = |imm[11:0];
    end else if (op == 6'd2) begin
      enc_c   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      bad_imm = ~j_ok;
    end else if (op == 6'd3) begin
      enc_c   = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      bad_imm = ~i_ok;
    end else if (op <= 6'd9) begin
      sub     = op - 6'd4;
      f3      = 3'((sub < 6'd2) ? sub : sub + 6'd2);
      enc_c   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      bad_imm = ~b_ok;
    end else if (op <= 6'd14) begin
      sub     = op - 6'd10;
      f3      = 3'((sub < 6'd3) ? sub : sub + 6'd1);
      enc_c   = {imm[11:0], rs1, f3, rd, OP_LOAD};
      bad_imm = ~i_ok;
    end else if (op <= 6'd17) begin
      sub     = op - 6'd15;
      f3      = 3'(sub);
      enc_c   = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      bad_imm = ~i_ok;
    end else if (op <= 6'd23) begin
      sub     = op - 6'd18;
      f3      = 3'((sub == 6'd0) ? sub : (sub <= 6'd3) ? sub + 6'd1 : sub + 6'd2);
      enc_c   = {imm[11:0], rs1, f3, rd, OP_IMM};
      bad_imm = ~i_ok;
    end else if (op <= 6'd26) begin
      f3      = (op == 6'd24) ? 3'b001 : 3'b101;
      f7      = (op == 6'd26) ? F7_ALT : 7'd0;
      enc_c   = {f7, imm[4:0], rs1, f3, rd, OP_IMM};
      bad_imm = |imm[31:5];
    end else if (op <= 6'd36) begin
      sub     = op - 6'd27;
      f3      = 3'((sub <= 6'd1) ? 6'd0 : (sub <= 6'd6) ? sub - 6'd1 : sub - 6'd2);
      f7      = (op == 6'd28 || op == 6'd34) ? F7_ALT : 7'd0;
      enc_c   = {f7, rs2, rs1, f3, rd, OP_REG};
    end else if (op <= 6'd44) begin
      sub     = op - 6'd37;
      f3      = 3'(sub);
      enc_c   = {F7_MUL, rs2, rs1, f3, rd, OP_REG};
    end else begin
      bad_op  = 1'b1;
    end
    if (bad_op | bad_imm) enc_c = NOP;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_acc)             state_nxt = RUN;
      RUN:     if (in_hs && bus.in_last)  state_nxt = DRAIN;
      DRAIN:   if (out_hs)                state_nxt = FIN;
      FIN:                                state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Output register, address counter and sticky first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_addr  <= '0;
      cnt           <= ADDR_W'(BASE_ADDR);
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
      err_addr      <= '0;
    end else begin
      done <= (state_nxt == FIN);
      if (start_acc) begin
        cnt      <= ADDR_W'(BASE_ADDR);
        err      <= 1'b0;
        err_code <= '0;
        err_addr <= '0;
      end
      if (in_hs) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= enc_c;
        bus.out_addr  <= cnt;
        cnt           <= cnt + ADDR_W'(1);
      end else if (out_hs) begin
        bus.out_valid <= 1'b0;
      end
      if (in_hs && (bad_op || bad_imm || wrap_c)) begin
        err <= 1'b1;
        if (!err) begin
          err_code <= bad_op ? 2'd2 : bad_imm ? 2'd1 : 2'd3;
          err_addr <= cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed RV32IM words.
module tb_instr_encoder;
  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] err_addr;
  int                tests;
  int                failed;
  int                cyc;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic begin_prog();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_prog();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Presents one instruction and waits (bounded) for its input handshake.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_last  = last;
    for (int n = 0; n < 20; n++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    tests++; if ({done, err, err_code} !== 4'b0) begin failed++; $display("FAIL reset_flags: got %b want 0000", {done, err, err_code}); end
    tests++; if (bus.out_instr !== 32'h0 || bus.out_addr !== '0) begin failed++; $display("FAIL reset_out_data: got %h/%h want 0/0", bus.out_instr, bus.out_addr); end
  endtask

  task automatic test_basic();
    bit ok;
    begin_prog();
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
    tests++; if (!ok) begin failed++; $display("FAIL t1_accept: in_ready never rose"); end
    tests++; if (bus.out_instr !== 32'h00500093) begin failed++; $display("FAIL t1_addi: got %h want 00500093", bus.out_instr); end
    tests++; if (bus.out_addr !== 10'd0 || bus.out_valid !== 1'b1) begin failed++; $display("FAIL t1_addr: got %0d v=%b want 0 v=1", bus.out_addr, bus.out_valid); end
    end_prog();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c0;
    begin_prog();
    send(6'd27, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h002081B3 || bus.out_addr !== 10'd0) begin failed++; $display("FAIL t2_add: got %h@%0d want 002081B3@0", bus.out_instr, bus.out_addr); end
    c0 = cyc;
    send(6'd37, 5'd10, 5'd11, 5'd12, 32'hDEAD_BEEF, 1'b1, ok);
    tests++; if (bus.out_instr !== 32'h02C58533 || bus.out_addr !== 10'd1) begin failed++; $display("FAIL t2_mul: got %h@%0d want 02C58533@1", bus.out_instr, bus.out_addr); end
    tests++; if (cyc - c0 !== 1) begin failed++; $display("FAIL t2_throughput: got %0d cycles want 1", cyc - c0); end
    end_prog();
  endtask

  task automatic test_formats();
    bit ok;
    begin_prog();
    send(6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'hFE208CE3) begin failed++; $display("FAIL t3_beq: got %h want FE208CE3", bus.out_instr); end
    send(6'd2, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h010000EF) begin failed++; $display("FAIL t3_jal: got %h want 010000EF", bus.out_instr); end
    send(6'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h123452B7 || bus.out_addr !== 10'd2) begin failed++; $display("FAIL t3_lui: got %h@%0d want 123452B7@2", bus.out_instr, bus.out_addr); end
    send(6'd26, 5'd4, 5'd5, 5'd0, 32'd3, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h4032D213) begin failed++; $display("FAIL t3_srai: got %h want 4032D213", bus.out_instr); end
    send(6'd17, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, ok);
    tests++; if (bus.out_instr !== 32'hFE20AE23) begin failed++; $display("FAIL t3_sw: got %h want FE20AE23", bus.out_instr); end
    tests++; if (err !== 1'b0) begin failed++; $display("FAIL t3_no_err: got %b want 0", err); end
    end_prog();
  endtask

  task automatic test_imm_bounds();
    bit ok;
    begin_prog();
    send(6'd18, 5'd1, 5'd0, 5'd31, 32'd2047, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h7FF00093) begin failed++; $display("FAIL imm_i_max: got %h want 7FF00093", bus.out_instr); end
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h80000093) begin failed++; $display("FAIL imm_i_min: got %h want 80000093", bus.out_instr); end
    send(6'd4, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h7E000FE3) begin failed++; $display("FAIL imm_b_max: got %h want 7E000FE3", bus.out_instr); end
    send(6'd2, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h8000006F) begin failed++; $display("FAIL imm_j_min: got %h want 8000006F", bus.out_instr); end
    tests++; if (err !== 1'b0) begin failed++; $display("FAIL imm_bounds_no_err: got %b want 0", err); end
    send(6'd5, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, ok);
    tests++; if (bus.out_instr !== 32'h00000013) begin failed++; $display("FAIL imm_b_odd: got %h want 00000013", bus.out_instr); end
    tests++; if ({err, err_code} !== 3'b101 || err_addr !== 10'd4) begin failed++; $display("FAIL imm_b_odd_err: got %b/%0d@%0d want 1/1@4", err, err_code, err_addr); end
    end_prog();
  endtask

  task automatic test_errors();
    bit ok;
    begin_prog();
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
    send(6'd18, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, ok);
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, ok);
    tests++; if (bus.out_instr !== 32'h00000013 || bus.out_addr !== 10'd2) begin failed++; $display("FAIL t4_nop: got %h@%0d want 00000013@2", bus.out_instr, bus.out_addr); end
    tests++; if ({err, err_code} !== 3'b101 || err_addr !== 10'd2) begin failed++; $display("FAIL t4_err: got %b/%0d@%0d want 1/1@2", err, err_code, err_addr); end
    send(6'd50, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, ok);
    tests++; if (bus.out_instr !== 32'h00000013 || bus.out_addr !== 10'd3) begin failed++; $display("FAIL t4_badop_nop: got %h@%0d want 00000013@3", bus.out_instr, bus.out_addr); end
    tests++; if ({err, err_code} !== 3'b101 || err_addr !== 10'd2) begin failed++; $display("FAIL t4_first_err: got %b/%0d@%0d want 1/1@2", err, err_code, err_addr); end
    end_prog();
  endtask

  task automatic test_backpressure();
    bit ok;
    begin_prog();
    tests++; if ({err, err_code} !== 3'b000 || err_addr !== '0) begin failed++; $display("FAIL t5_start_clears: got %b/%0d@%0d want 0/0@0", err, err_code, err_addr); end
    bus.out_ready = 1'b0;
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
    bus.in_valid = 1'b1;
    bus.in_op    = 6'd18;
    bus.in_rd    = 5'd2;
    bus.in_rs1   = 5'd0;
    bus.in_rs2   = 5'd0;
    bus.in_imm   = 32'd2;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.out_instr !== 32'h00100093 || bus.out_addr !== 10'd0 || bus.out_valid !== 1'b1) begin failed++; $display("FAIL t5_hold[%0d]: got %h@%0d v=%b want 00100093@0 v=1", i, bus.out_instr, bus.out_addr, bus.out_valid); end
      tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL t5_stall_ready[%0d]: got %b want 0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL t5_release_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if (bus.out_instr !== 32'h00200113 || bus.out_addr !== 10'd1) begin failed++; $display("FAIL t5_next: got %h@%0d want 00200113@1", bus.out_instr, bus.out_addr); end
    end_prog();
  endtask

  task automatic test_last_and_rst();
    bit ok;
    begin_prog();
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
    send(6'd18, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, ok);
    send(6'd18, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1, ok);
    tests++; if (bus.in_ready !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL t6_after_last: got rdy=%b done=%b want 0/0", bus.in_ready, done); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin failed++; $display("FAIL t6_done_pulse: got %b want 1", done); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL t6_done_clear: got %b want 0", done); end
    begin_prog();
    bus.out_ready = 1'b0;
    send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, ok);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin failed++; $display("FAIL t6_rst: got v=%b rdy=%b want 0/0", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL t6_rst_idle: got v=%b want 0", bus.out_valid); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    for (int v = 0; v < 2; v++) begin
      begin_prog();
      all_ok = 1'b1;
      for (int k = 0; k < 1023; k++) begin
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0, ok);
        all_ok &= ok;
      end
      send(6'd18, 5'd1, 5'd0, 5'd0, (v == 0) ? 32'd7 : 32'd4096, 1'b0, ok);
      all_ok &= ok;
      tests++; if (!all_ok) begin failed++; $display("FAIL wrap_accept[%0d]: some word not accepted", v); end
      tests++; if (bus.out_addr !== 10'd1023 || bus.out_instr !== ((v == 0) ? 32'h00700093 : 32'h00000013)) begin failed++; $display("FAIL wrap_word[%0d]: got %h@%0d", v, bus.out_instr, bus.out_addr); end
      tests++; if (err !== 1'b1 || err_code !== ((v == 0) ? 2'd3 : 2'd1) || err_addr !== 10'd1023) begin failed++; $display("FAIL wrap_err[%0d]: got %b/%0d@%0d want 1/%0d@1023", v, err, err_code, err_addr, (v == 0) ? 3 : 1); end
      send(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, ok);
      tests++; if (bus.out_addr !== 10'd0) begin failed++; $display("FAIL wrap_addr0[%0d]: got %0d want 0", v, bus.out_addr); end
      end_prog();
    end
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    cyc           = 0;
    rst           = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_formats();
    test_imm_bounds();
    test_errors();
    test_backpressure();
    test_last_and_rst();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
